// File: rtl/stk_pipe_wb_mc.sv
// Multi-context stack write-back stage: commits PUSH/POP/CLR per context, issues RAM writes,
// and returns responses through a 2-entry queue. Optional per-context error counters: STK_PIPE_WB_MC_ERR_CNT_EN.
module stk_pipe_wb_mc #(
    parameter  int W     = 32,
    parameter  int NCTX  = 4,
    parameter  int DEPTH = 16,
    localparam int CTX_W = (NCTX > 1) ? $clog2(NCTX) : 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [CTX_W-1:0]      in_ctx,
    input  logic [1:0]            in_op,
    input  logic [W-1:0]          in_dat,
    input  logic [W-1:0]          in_rd_dat,
    output logic [NCTX*CW-1:0]    ptr_o,
    output logic                  mem_wr_en,
    output logic [CTX_W+AW-1:0]   mem_wr_addr,
    output logic [W-1:0]          mem_wr_dat,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [CTX_W-1:0]      rsp_ctx,
    output logic [W-1:0]          rsp_dat,
    output logic                  rsp_err,
    output logic [NCTX*8-1:0]     err_cnt_o
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef struct packed {
        logic [CTX_W-1:0] ctx;
        logic [W-1:0]     dat;
        logic             err;
    } rsp_t;

    op_e             op;
    logic [CW-1:0]   ptr [NCTX];
    logic [CW-1:0]   ptr_cur;
    logic [CW-1:0]   ptr_nxt;
    logic            acc;
    logic            enq;
    logic            deq;
    logic            do_wr;
    rsp_t            new_rsp;
    rsp_t            q0;
    rsp_t            q1;
    logic [1:0]      cnt;
    logic [1:0]      cnt_nxt;

    assign op = op_e'(in_op);

    always_comb begin
        ptr_cur = '0;
        for (int unsigned c = 0; c < NCTX; c++)
            if (c == 32'(in_ctx)) ptr_cur = ptr[c];
    end

    always_comb begin
        acc     = in_vld & in_rdy;
        enq     = acc & (op != OP_NOP);
        do_wr   = 1'b0;
        ptr_nxt = ptr_cur;
        new_rsp = '{ctx: in_ctx, dat: '0, err: 1'b0};
        unique case (op)
            OP_PUSH: begin
                new_rsp.dat = in_dat;
                if (ptr_cur == CW'(DEPTH)) begin
                    new_rsp.err = 1'b1;
                end else begin
                    do_wr   = acc;
                    ptr_nxt = ptr_cur + CW'(1);
                end
            end
            OP_POP: begin
                if (ptr_cur == '0) begin
                    new_rsp.err = 1'b1;
                end else begin
                    new_rsp.dat = in_rd_dat;
                    ptr_nxt     = ptr_cur - CW'(1);
                end
            end
            OP_CLR: begin
                new_rsp.dat = W'(ptr_cur);
                ptr_nxt     = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int unsigned c = 0; c < NCTX; c++) ptr[c] <= '0;
        end else if (enq) begin
            for (int unsigned c = 0; c < NCTX; c++)
                if (c == 32'(in_ctx)) ptr[c] <= ptr_nxt;
        end
    end

    always_comb begin
        ptr_o = '0;
        for (int unsigned c = 0; c < NCTX; c++) ptr_o[c*CW +: CW] = ptr[c];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_dat  <= '0;
        end else begin
            mem_wr_en <= do_wr;
            if (do_wr) begin
                mem_wr_addr <= {in_ctx, ptr_cur[AW-1:0]};
                mem_wr_dat  <= in_dat;
            end
        end
    end

    // Head entry drives rsp_*; in_rdy is the registered "not full" of the next occupancy.
    assign deq     = (cnt != 2'd0) & rsp_rdy;
    assign cnt_nxt = cnt + {1'b0, enq} - {1'b0, deq};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt    <= '0;
            q0     <= '0;
            q1     <= '0;
            in_rdy <= 1'b1;
        end else begin
            cnt    <= cnt_nxt;
            in_rdy <= (cnt_nxt != 2'd2);
            if (deq) begin
                q0 <= enq ? new_rsp : q1;
            end else if (enq) begin
                if (cnt == 2'd0) q0 <= new_rsp;
                else             q1 <= new_rsp;
            end
        end
    end

    assign rsp_vld = (cnt != 2'd0);
    assign rsp_ctx = q0.ctx;
    assign rsp_dat = q0.dat;
    assign rsp_err = q0.err;

`ifdef STK_PIPE_WB_MC_ERR_CNT_EN
    logic [7:0] err_cnt [NCTX];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int unsigned c = 0; c < NCTX; c++) err_cnt[c] <= '0;
        end else if (enq) begin
            for (int unsigned c = 0; c < NCTX; c++) begin
                if (c == 32'(in_ctx)) begin
                    if (op == OP_CLR)
                        err_cnt[c] <= '0;
                    else if (new_rsp.err && (err_cnt[c] != '1))
                        err_cnt[c] <= err_cnt[c] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        err_cnt_o = '0;
        for (int unsigned c = 0; c < NCTX; c++) err_cnt_o[c*8 +: 8] = err_cnt[c];
    end
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stk_pipe_wb_mc.sv
// Self-checking bench for stk_pipe_wb_mc: directed scenarios then random ops, checked
// against a stack/queue reference model kept in plain arrays and a queue.
module tb_stk_pipe_wb_mc;

    localparam int W = 32, NCTX = 4, DEPTH = 16, CTX_W = 2, AW = 4, CW = 5;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic                 in_vld;
    logic                 in_rdy;
    logic [CTX_W-1:0]     in_ctx;
    logic [1:0]           in_op;
    logic [W-1:0]         in_dat;
    logic [W-1:0]         in_rd_dat;
    logic [NCTX*CW-1:0]   ptr_o;
    logic                 mem_wr_en;
    logic [CTX_W+AW-1:0]  mem_wr_addr;
    logic [W-1:0]         mem_wr_dat;
    logic                 rsp_vld;
    logic                 rsp_rdy;
    logic [CTX_W-1:0]     rsp_ctx;
    logic [W-1:0]         rsp_dat;
    logic                 rsp_err;
    logic [NCTX*8-1:0]    err_cnt_o;

    stk_pipe_wb_mc #(.W(W), .NCTX(NCTX), .DEPTH(DEPTH)) dut (
        .clk(clk), .arst_n(arst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_ctx(in_ctx),
        .in_op(in_op), .in_dat(in_dat), .in_rd_dat(in_rd_dat), .ptr_o(ptr_o),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_dat(mem_wr_dat),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_ctx(rsp_ctx), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ctx;
        logic [31:0] dat;
        bit          err;
    } rsp_m;

    int          n_asrt = 0;
    int          n_fail = 0;
    int          mptr [NCTX];
    int          merr [NCTX];
    logic [31:0] mmem [NCTX][DEPTH];
    rsp_m        expq [$];
    bit          exp_wr;
    int          exp_waddr;
    logic [31:0] exp_wdat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_ptrs();
        logic [63:0] v = '0;
        for (int c = 0; c < NCTX; c++) v[c*CW +: CW] = mptr[c][CW-1:0];
        return v;
    endfunction

    function automatic logic [63:0] exp_errs();
        logic [63:0] v = '0;
`ifdef STK_PIPE_WB_MC_ERR_CNT_EN
        for (int c = 0; c < NCTX; c++) v[c*8 +: 8] = merr[c][7:0];
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCTX; c++) begin
            mptr[c] = 0;
            merr[c] = 0;
        end
        expq.delete();
        exp_wr = 1'b0;
    endtask

    task automatic model_err(input int c);
        if (merr[c] < 255) merr[c]++;
    endtask

    // Reference behaviour of one accepted operation.
    task automatic model_op(input int c, input int o, input logic [31:0] d, input logic [31:0] rd);
        rsp_m r;
        r.ctx = c;
        r.dat = '0;
        r.err = 1'b0;
        case (o)
            1: begin
                r.dat = d;
                if (mptr[c] == DEPTH) begin
                    r.err = 1'b1;
                    model_err(c);
                end else begin
                    exp_wr    = 1'b1;
                    exp_waddr = c * DEPTH + mptr[c];
                    exp_wdat  = d;
                    mmem[c][mptr[c]] = d;
                    mptr[c]++;
                end
            end
            2: begin
                if (mptr[c] == 0) begin
                    r.err = 1'b1;
                    model_err(c);
                end else begin
                    r.dat = rd;
                    mptr[c]--;
                end
            end
            3: begin
                r.dat   = 32'(mptr[c]);
                mptr[c] = 0;
                merr[c] = 0;
            end
            default: ;
        endcase
        if (o != 0) expq.push_back(r);
    endtask

    task automatic tick();
        bit   rdy_m;
        rsp_m h;
        rdy_m = (expq.size() < 2);
        chk("in_rdy", in_rdy, rdy_m);
        chk("rsp_vld", rsp_vld, expq.size() != 0);
        if (expq.size() != 0) begin
            h = expq[0];
            chk("rsp_ctx", rsp_ctx, h.ctx);
            chk("rsp_dat", rsp_dat, h.dat);
            chk("rsp_err", rsp_err, h.err);
            if (rsp_rdy) void'(expq.pop_front());
        end
        exp_wr = 1'b0;
        if (in_vld && rdy_m) model_op(int'(in_ctx), int'(in_op), in_dat, in_rd_dat);
        @(posedge clk);
        #1;
        chk("mem_wr_en", mem_wr_en, exp_wr);
        if (exp_wr) begin
            chk("mem_wr_addr", mem_wr_addr, exp_waddr);
            chk("mem_wr_dat", mem_wr_dat, exp_wdat);
        end
        chk("ptr_o", ptr_o, exp_ptrs());
        chk("err_cnt_o", err_cnt_o, exp_errs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_op(input int c, input int o, input logic [31:0] d, input bit rnd_rdy);
        bit acc;
        in_vld    = 1'b1;
        in_ctx    = CTX_W'(c);
        in_op     = 2'(o);
        in_dat    = d;
        in_rd_dat = (mptr[c] > 0) ? mmem[c][mptr[c]-1] : $urandom;
        for (int i = 0; i < 64; i++) begin
            if (rnd_rdy) rsp_rdy = ($urandom_range(0, 3) != 0);
            acc = (expq.size() < 2);
            tick();
            if (acc) break;
            if (i == 63) begin
                n_asrt++;
                n_fail++;
                $error("FAIL accept_timeout observed=stalled expected=accepted");
            end
        end
        in_vld = 1'b0;
    endtask

    initial begin
        arst_n    = 1'b0;
        in_vld    = 1'b0;
        in_ctx    = '0;
        in_op     = '0;
        in_dat    = '0;
        in_rd_dat = '0;
        rsp_rdy   = 1'b1;
        model_reset();
        #12;
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_ptr_o", ptr_o, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_wr_addr", mem_wr_addr, 0);
        chk("rst_mem_wr_dat", mem_wr_dat, 0);
        chk("rst_rsp", {rsp_ctx, rsp_dat, rsp_err}, 0);
        chk("rst_err_cnt", err_cnt_o, 0);
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk);
        #1;

        // single push, then fill ctx2 past full
        do_op(0, 1, 32'hA5, 1'b0);
        chk("t1_addr", mem_wr_addr, 0);
        idle(2);
        for (int i = 0; i < 17; i++) do_op(2, 1, $urandom, 1'b0);
        idle(2);
        chk("t2_ptr2_full", ptr_o[2*CW +: CW], DEPTH);

        // underflow then push/pop round trip on ctx1
        do_op(1, 2, $urandom, 1'b0);
        do_op(1, 1, 32'h11, 1'b0);
        do_op(1, 2, $urandom, 1'b0);
        idle(2);
        chk("t3_ptr1", ptr_o[1*CW +: CW], 0);

        // backpressure: third push stalls until responses drain
        rsp_rdy = 1'b0;
        do_op(0, 1, 32'hB0, 1'b0);
        do_op(0, 1, 32'hB1, 1'b0);
        in_vld = 1'b1; in_ctx = 2'd0; in_op = 2'd1; in_dat = 32'hB2;
        idle(3);
        chk("t4_in_rdy_low", in_rdy, 0);
        rsp_rdy = 1'b1;
        do_op(0, 1, 32'hB2, 1'b0);
        idle(3);

        // interleaved contexts then clear ctx3
        for (int i = 0; i < 5; i++) begin
            do_op(0, 1, $urandom, 1'b0);
            do_op(3, 1, $urandom, 1'b0);
        end
        do_op(3, 3, $urandom, 1'b0);
        idle(2);
        chk("t5_ptr3", ptr_o[3*CW +: CW], 0);
        chk("t5_ptr0", ptr_o[0*CW +: CW], 9);

        // reset with two queued responses
        rsp_rdy = 1'b0;
        do_op(1, 1, $urandom, 1'b0);
        do_op(1, 1, $urandom, 1'b0);
        #2;
        arst_n = 1'b0;
        #1;
        chk("t6_rsp_vld", rsp_vld, 0);
        chk("t6_ptr_o", ptr_o, 0);
        chk("t6_mem_wr_en", mem_wr_en, 0);
        chk("t6_err_cnt", err_cnt_o, 0);
        model_reset();
        @(negedge clk) arst_n = 1'b1;
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        for (int n = 0; n < 300; n++) begin
            int r;
            int o;
            r = $urandom_range(0, 9);
            o = (r == 0) ? 0 : (r <= 5) ? 1 : (r <= 8) ? 2 : 3;
            do_op($urandom_range(0, NCTX - 1), o, $urandom, 1'b1);
        end
        rsp_rdy = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
